// File: rtl/key_loader_pkg.sv
// Shared types and constants for the serial key loader.
package key_loader_pkg;

    localparam int unsigned CHECK_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CHECK   = 2'd2,
        LOCKOUT = 2'd3
    } kl_state_t;

    // Total serial frame length: key bits followed by the check byte.
    function automatic int unsigned frame_len(input int unsigned key_w);
        return key_w + CHECK_W;
    endfunction

endpackage

// File: rtl/key_loader_if.sv
// Serial load handshake and parallel key bus between the provisioner and the locked netlist.
interface key_loader_if #(
    parameter int unsigned KEY_W    = 32,
    parameter int unsigned MAX_FAIL = 3
);
    localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);

    logic              load_start;
    logic              sd_valid;
    logic              sd_bit;
    logic              sd_ready;
    logic [KEY_W-1:0]  key_out;
    logic              key_valid;
    logic              load_err;
    logic              locked_out;
    logic [FAIL_W-1:0] fail_cnt;

    modport master (
        output load_start, sd_valid, sd_bit,
        input  sd_ready, key_out, key_valid, load_err, locked_out, fail_cnt
    );

    modport slave (
        input  load_start, sd_valid, sd_bit,
        output sd_ready, key_out, key_valid, load_err, locked_out, fail_cnt
    );

endinterface

// File: rtl/key_xor_fold.sv
// Combinational XOR of all key bytes into one check byte.
module key_xor_fold
    import key_loader_pkg::*;
#(
    parameter int unsigned KEY_W = 32
) (
    input  logic [KEY_W-1:0]   key,
    output logic [CHECK_W-1:0] fold_c
);

    always_comb begin
        fold_c = '0;
        for (int i = 0; i < int'(KEY_W / CHECK_W); i++) begin
            fold_c = fold_c ^ key[i*CHECK_W +: CHECK_W];
        end
    end

endmodule

// File: rtl/key_loader.sv
// Receives a serial key frame, verifies its check byte and presents the key on a parallel bus;
// repeated failures latch a lockout that only reset clears.
module key_loader
    import key_loader_pkg::*;
#(
    parameter int unsigned      KEY_W     = 32,
    parameter int unsigned      MAX_FAIL  = 3,
    parameter logic [KEY_W-1:0] DECOY_KEY = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    key_loader_if.slave    bus
);

    localparam int unsigned FRAME_W = frame_len(KEY_W);
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
    localparam int unsigned FAIL_W  = $clog2(MAX_FAIL + 1);

    kl_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] shadow_q, shadow_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               lock_q, lock_d;
    logic [FAIL_W-1:0]  fail_q, fail_d;

    logic [CHECK_W-1:0] fold_c;
    logic               match_c;
    logic               accept_c;
    logic               last_bit_c;
    logic [FAIL_W-1:0]  fail_inc_c;
    logic               hit_max_c;

    key_xor_fold #(.KEY_W(KEY_W)) u_fold (
        .key    (shadow_q[KEY_W-1:0]),
        .fold_c (fold_c)
    );

    // Shadow shifts right, so frame bit 0 ends up in shadow_q[0].
    assign match_c    = (fold_c == shadow_q[FRAME_W-1:KEY_W]);
    assign accept_c   = bus.sd_valid && (state_q == SHIFT);
    assign last_bit_c = (cnt_q == CNT_W'(FRAME_W - 1));
    assign fail_inc_c = fail_q + FAIL_W'(1);
    assign hit_max_c  = (fail_inc_c == FAIL_W'(MAX_FAIL));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.load_start) state_d = SHIFT;
            SHIFT:   if (!bus.load_start && accept_c && last_bit_c) state_d = CHECK;
            CHECK:   state_d = (!match_c && hit_max_c) ? LOCKOUT : IDLE;
            LOCKOUT: state_d = LOCKOUT;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        key_d    = key_q;
        valid_d  = valid_q;
        err_d    = 1'b0;
        lock_d   = lock_q;
        fail_d   = fail_q;
        unique case (state_q)
            IDLE: begin
                if (bus.load_start) begin
                    cnt_d    = '0;
                    shadow_d = '0;
                end
            end
            SHIFT: begin
                if (bus.load_start) begin
                    cnt_d    = '0;
                    shadow_d = '0;
                end else if (accept_c) begin
                    shadow_d = {bus.sd_bit, shadow_q[FRAME_W-1:1]};
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            CHECK: begin
                if (match_c) begin
                    key_d   = shadow_q[KEY_W-1:0];
                    valid_d = 1'b1;
                    fail_d  = '0;
                end else begin
                    err_d   = 1'b1;
                    key_d   = DECOY_KEY;
                    valid_d = 1'b0;
                    fail_d  = fail_inc_c;
                    if (hit_max_c) lock_d = 1'b1;
                end
            end
            LOCKOUT: begin
                lock_d  = 1'b1;
                key_d   = DECOY_KEY;
                valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            key_q    <= DECOY_KEY;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            lock_q   <= 1'b0;
            fail_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            key_q    <= key_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            lock_q   <= lock_d;
            fail_q   <= fail_d;
        end
    end

    assign bus.sd_ready   = (state_q == SHIFT);
    assign bus.key_out    = key_q;
    assign bus.key_valid  = valid_q;
    assign bus.load_err   = err_q;
    assign bus.locked_out = lock_q;
    assign bus.fail_cnt   = fail_q;

endmodule

// File: tb/tb_key_loader.sv
// Self-checking bench for key_loader: directed frames plus randomized gapped frames vs a reference model.
module tb_key_loader;
    import key_loader_pkg::*;

    localparam int unsigned KEY_W    = 32;
    localparam int unsigned MAX_FAIL = 3;
    localparam logic [31:0] DECOY    = 32'h0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_loader_if #(.KEY_W(KEY_W), .MAX_FAIL(MAX_FAIL)) bus ();

    key_loader #(.KEY_W(KEY_W), .MAX_FAIL(MAX_FAIL), .DECOY_KEY(DECOY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int hold_bad;

    // Reference model state
    logic [31:0] m_key;
    logic        m_valid;
    int          m_fail;
    logic        m_locked;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_fold(input logic [31:0] k);
        return k[7:0] ^ k[15:8] ^ k[23:16] ^ k[31:24];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_key    = DECOY;
        m_valid  = 1'b0;
        m_fail   = 0;
        m_locked = 1'b0;
    endtask

    // Key bus must keep the old verified key and ready must reflect lockout throughout a frame.
    task automatic hold_probe();
        if (bus.key_out !== m_key || bus.key_valid !== m_valid || bus.sd_ready !== !m_locked)
            hold_bad++;
    endtask

    task automatic send_bits(input logic [39:0] frame, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.sd_valid = 1'b0;
                bus.sd_bit   = 1'($urandom);
                hold_probe();
                tick();
            end
            bus.sd_valid = 1'b1;
            bus.sd_bit   = frame[i];
            hold_probe();
            tick();
        end
        bus.sd_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [31:0] key, input logic [7:0] chk,
                             input bit gaps, input int abort_at);
        logic [39:0] frame;
        logic        exp_err;
        frame    = {chk, key};
        hold_bad = 0;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        if (abort_at > 0) begin
            send_bits(frame, abort_at, gaps);
            bus.load_start = 1'b1;
            tick();
            bus.load_start = 1'b0;
        end
        send_bits(frame, 40, gaps);
        check_eq({tag, "_hold"}, 64'(hold_bad), 64'd0);
        // Last bit just accepted: still the old key until CHECK completes.
        check_eq({tag, "_pre_key"}, 64'(bus.key_out), 64'(m_key));
        tick();
        exp_err = 1'b0;
        if (!m_locked) begin
            if (chk == ref_fold(key)) begin
                m_key = key; m_valid = 1'b1; m_fail = 0;
            end else begin
                m_key = DECOY; m_valid = 1'b0; m_fail++; exp_err = 1'b1;
                if (m_fail == int'(MAX_FAIL)) m_locked = 1'b1;
            end
        end
        check_eq({tag, "_key"},   64'(bus.key_out),    64'(m_key));
        check_eq({tag, "_valid"}, 64'(bus.key_valid),  64'(m_valid));
        check_eq({tag, "_err"},   64'(bus.load_err),   64'(exp_err));
        check_eq({tag, "_fail"},  64'(bus.fail_cnt),   64'(m_fail));
        check_eq({tag, "_lock"},  64'(bus.locked_out), 64'(m_locked));
        tick();
        check_eq({tag, "_err_clr"}, 64'(bus.load_err), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_key"},   64'(bus.key_out),    64'(DECOY));
        check_eq({tag, "_valid"}, 64'(bus.key_valid),  64'd0);
        check_eq({tag, "_ready"}, 64'(bus.sd_ready),   64'd0);
        check_eq({tag, "_fail"},  64'(bus.fail_cnt),   64'd0);
        check_eq({tag, "_lock"},  64'(bus.locked_out), 64'd0);
        check_eq({tag, "_err"},   64'(bus.load_err),   64'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_reset_vals("rst_pulse");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [31:0] k;
        logic [7:0]  c;
        bus.load_start = 1'b0;
        bus.sd_valid   = 1'b0;
        bus.sd_bit     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Good frame, sd_valid held: key visible 41 edges after the load_start edge.
        run_frame("good", 32'h1234_5678, 8'h08, 1'b0, 0);
        run_frame("bad1", 32'h1234_5678, 8'h09, 1'b0, 0);
        run_frame("bad2", 32'h1234_5678, 8'h10, 1'b0, 0);
        run_frame("bad3", 32'hCAFE_0001, 8'h00, 1'b0, 0);
        // Locked: ready stays low, good frame has no effect.
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        check_eq("lock_ready", 64'(bus.sd_ready), 64'd0);
        run_frame("locked_good", 32'h1234_5678, 8'h08, 1'b0, 0);
        pulse_reset();
        run_frame("post_rst", 32'h1234_5678, 8'h08, 1'b0, 0);

        // Restart mid-frame keeps the old key until the new CHECK.
        run_frame("a5", 32'hA5A5_A5A5, 8'h00, 1'b0, 0);
        run_frame("restart", 32'hDEAD_BEEF, 8'h22, 1'b0, 10);

        // Asynchronous reset mid-frame.
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.sd_valid = 1'b1;
            bus.sd_bit   = 1'($urandom);
            tick();
        end
        bus.sd_valid = 1'b0;
        check_eq("mid_valid_before", 64'(bus.key_valid), 64'd1);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_reset_vals("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Randomized gapped frames, some with corrupted check bytes.
        for (int n = 0; n < 12; n++) begin
            if (m_locked) pulse_reset();
            k = $urandom;
            c = ref_fold(k);
            if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
            run_frame("rand", k, c, 1'b1, ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 39)) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
